// File: rtl/ps2_key_fifo.sv
// Keyboard event front-end: turns hps_io ps2_key toggles into queued events,
// optionally filters typematic repeat, and buffers them in a FWFT FIFO.
module ps2_key_fifo #(
  parameter int DEPTH         = 8,
  parameter int FILTER_REPEAT = 1,
  parameter int OVF_MODE      = 0
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [10:0]              ps2_key,
  input  logic                     rd,
  input  logic                     clr_ovf,
  output logic                     key_valid,
  output logic                     key_pressed,
  output logic                     key_ext,
  output logic [7:0]               key_code,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             old_stb_q, old_stb_d;
  logic [511:0]     held_q, held_d;
  logic [9:0]       mem_q [DEPTH];
  logic [9:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic       ev, acc, pop, full, push, lost, ovw;
  logic [8:0] idx;
  logic [9:0] head;

  always_comb begin
    old_stb_d = ps2_key[10];
    ev        = ps2_key[10] ^ old_stb_q;
    idx       = ps2_key[8:0];
    acc       = ev && !((FILTER_REPEAT != 0) && ps2_key[9] && held_q[idx]);
    pop       = rd && (count_q != '0);
    full      = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    push      = acc && (!full || pop);
    lost      = acc && full && !pop;
    ovw       = lost && (OVF_MODE != 0);

    held_d = held_q;
    if (ev) held_d[idx] = ps2_key[9];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push || ovw) begin
      mem_d[wr_ptr_q] = ps2_key[9:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop || ovw) rd_ptr_d = rd_ptr_q + AW'(1);

    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = (ovf_q && !clr_ovf) || lost;
  end

  always_ff @(posedge clk_sys) begin
    old_stb_q <= old_stb_d;
    mem_q     <= mem_d;
    if (reset) begin
      held_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      held_q   <= held_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Head fields are forced to zero while empty so reset values are well defined.
  always_comb begin
    head        = mem_q[rd_ptr_q];
    key_valid   = (count_q != '0);
    key_pressed = key_valid && head[9];
    key_ext     = key_valid && head[8];
    key_code    = key_valid ? head[7:0] : 8'h00;
    count       = count_q;
    overflow    = ovf_q;
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Randomised bench for ps2_key_fifo: three configurations share one stimulus
// stream and are checked every cycle against a queue-based event model.
module tb_ps2_key_fifo;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       stb = 1'b0, kp = 1'b0, ke = 1'b0;
  logic [7:0] kc  = 8'h00;
  logic       rd = 1'b0, clr_ovf = 1'b0;
  logic [10:0] ps2_key;
  assign ps2_key = {stb, kp, ke, kc};

  always #5 clk_sys = ~clk_sys;

  logic       v0, p0, e0, o0, v1, p1, e1, o1, v2, p2, e2, o2;
  logic [7:0] c0, c1, c2;
  logic [3:0] n0, n1;
  logic [1:0] n2;

  ps2_key_fifo #(.DEPTH(8), .FILTER_REPEAT(1), .OVF_MODE(0)) u0 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .rd(rd), .clr_ovf(clr_ovf),
    .key_valid(v0), .key_pressed(p0), .key_ext(e0), .key_code(c0), .count(n0), .overflow(o0));
  ps2_key_fifo #(.DEPTH(8), .FILTER_REPEAT(0), .OVF_MODE(1)) u1 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .rd(rd), .clr_ovf(clr_ovf),
    .key_valid(v1), .key_pressed(p1), .key_ext(e1), .key_code(c1), .count(n1), .overflow(o1));
  ps2_key_fifo #(.DEPTH(2), .FILTER_REPEAT(1), .OVF_MODE(1)) u2 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .rd(rd), .clr_ovf(clr_ovf),
    .key_valid(v2), .key_pressed(p2), .key_ext(e2), .key_code(c2), .count(n2), .overflow(o2));

  int DEP [3] = '{8, 8, 2};
  bit FR  [3] = '{1'b1, 1'b0, 1'b1};
  bit OM  [3] = '{1'b0, 1'b1, 1'b1};

  logic [9:0] mq [3][$];
  bit         mheld [3][512];
  bit         movf [3];
  bit         mold [3];

  int  n_assert = 0;
  int  n_fail   = 0;
  bit  chk_en   = 1'b0;

  function automatic void cmp(string name, int c, logic [31:0] act, logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, c, $time, act, exp);
    end
  endfunction

  function automatic void model_step(int c);
    bit ev, pop, full, acc;
    logic [8:0] idx;
    if (reset) begin
      mq[c].delete();
      for (int i = 0; i < 512; i++) mheld[c][i] = 1'b0;
      movf[c] = 1'b0;
      mold[c] = stb;
      return;
    end
    ev = (stb != mold[c]);
    mold[c] = stb;
    idx  = {ke, kc};
    pop  = rd && (mq[c].size() > 0);
    full = (mq[c].size() == DEP[c]);
    acc  = 1'b0;
    if (ev) begin
      acc = !(FR[c] && kp && mheld[c][idx]);
      mheld[c][idx] = kp;
    end
    if (clr_ovf) movf[c] = 1'b0;
    if (pop) void'(mq[c].pop_front());
    if (acc) begin
      if (!full || pop) mq[c].push_back({kp, ke, kc});
      else begin
        movf[c] = 1'b1;
        if (OM[c]) begin
          void'(mq[c].pop_front());
          mq[c].push_back({kp, ke, kc});
        end
      end
    end
  endfunction

  always @(posedge clk_sys) begin
    for (int c = 0; c < 3; c++) model_step(c);
  end

  task automatic check_dut(int c, logic v, logic p, logic e, logic [7:0] k, int n, logic o);
    logic [9:0] h;
    h = (mq[c].size() > 0) ? mq[c][0] : 10'h000;
    cmp("key_valid",   c, 32'(v), 32'(mq[c].size() > 0));
    cmp("key_pressed", c, 32'(p), 32'(h[9]));
    cmp("key_ext",     c, 32'(e), 32'(h[8]));
    cmp("key_code",    c, 32'(k), 32'(h[7:0]));
    cmp("count",       c, 32'(n), 32'(mq[c].size()));
    cmp("overflow",    c, 32'(o), 32'(movf[c]));
  endtask

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check_dut(0, v0, p0, e0, c0, int'(n0), o0);
      check_dut(1, v1, p1, e1, c1, int'(n1), o1);
      check_dut(2, v2, p2, e2, c2, int'(n2), o2);
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic send(logic p, logic e, logic [7:0] k);
    kp = p; ke = e; kc = k; stb = ~stb;
    tick();
  endtask

  task automatic pop_n(int n);
    rd = 1'b1;
    repeat (n) tick();
    rd = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    tick();
    cmp("rst_valid", 0, 32'(v0), 32'd0);
    cmp("rst_count", 0, 32'(n0), 32'd0);
    cmp("rst_code",  0, 32'(c0), 32'h00);

    // single make, then pop
    send(1'b1, 1'b0, 8'h1C);
    cmp("t1_valid", 0, 32'(v0), 32'd1);
    cmp("t1_code",  0, 32'(c0), 32'h1C);
    cmp("t1_press", 0, 32'(p0), 32'd1);
    cmp("t1_count", 0, 32'(n0), 32'd1);
    pop_n(1);
    cmp("t1_valid_after_rd", 0, 32'(v0), 32'd0);
    cmp("t1_count_after_rd", 0, 32'(n0), 32'd0);

    // typematic filtering
    repeat (3) send(1'b1, 1'b0, 8'h2A);
    send(1'b0, 1'b0, 8'h2A);
    cmp("t2_filter_count",   0, 32'(n0), 32'd2);
    cmp("t2_nofilter_count", 1, 32'(n1), 32'd4);
    cmp("t2_model_depth",    0, 32'(mq[0].size()), 32'd2);
    pop_n(5);

    // overflow, both modes
    for (int i = 1; i <= 9; i++) send(1'b1, 1'b0, 8'(i));
    cmp("t3_count", 0, 32'(n0), 32'd8);
    cmp("t3_ovf",   0, 32'(o0), 32'd1);
    cmp("t4_count", 1, 32'(n1), 32'd8);
    cmp("t4_ovf",   1, 32'(o1), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      cmp("t3_pop_code", 0, 32'(c0), 32'(i));
      cmp("t4_pop_code", 1, 32'(c1), 32'(i + 1));
      pop_n(1);
    end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    cmp("t3_ovf_clr", 0, 32'(o0), 32'd0);

    // full FIFO with simultaneous push/pop, across pointer wrap
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0, 8'(8'h10 + i));
    rd = 1'b1;
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1, 8'(8'h20 + i));
    rd = 1'b0;
    cmp("t5_count", 0, 32'(n0), 32'd8);
    cmp("t5_ovf",   0, 32'(o0), 32'd0);
    cmp("t5_head",  0, 32'(c0), 32'h22);
    pop_n(10);

    // reset mid-operation with a coincident toggle
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 8'(8'h30 + i));
    send(1'b1, 1'b0, 8'h1C);
    kp = 1'b1; kc = 8'h44; stb = ~stb; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    cmp("t6_valid", 0, 32'(v0), 32'd0);
    cmp("t6_count", 0, 32'(n0), 32'd0);
    cmp("t6_code",  0, 32'(c0), 32'h00);
    cmp("t6_ovf",   0, 32'(o0), 32'd0);
    send(1'b1, 1'b0, 8'h1C);
    cmp("t6_make_after_rst", 0, 32'(n0), 32'd1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        kp = 1'($urandom_range(0, 1));
        ke = 1'($urandom_range(0, 3) == 0);
        kc = 8'($urandom_range(0, 5));
        stb = ~stb;
      end
      rd      = ($urandom_range(0, 3) == 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rd = 1'b0; clr_ovf = 1'b0; reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
